// File: rtl/digit_sequencer.sv
// Debounced up/down 3-bit code sequencer driving a seven-segment decoder {A,B,C}.
// Optional auto-run stepping is built when DIGIT_SEQUENCER_AUTO_RUN_EN is defined.
module digit_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_up,
  input  logic btn_dn,
  input  logic clr,
`ifdef DIGIT_SEQUENCER_AUTO_RUN_EN
  input  logic run,
`endif
  output logic A,
  output logic B,
  output logic C,
  output logic upd
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  // index 0 = btn_up, index 1 = btn_dn
  logic [1:0]      btn_meta;
  logic [1:0]      btn_sync;
  logic [1:0]      deb;
  logic [1:0][7:0] cnt;
  logic [1:0]      rise;
  logic            tick;
  logic [2:0]      code;
  logic [2:0]      code_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      btn_meta <= {btn_dn, btn_up};
      btn_sync <= btn_meta;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
      cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_sync[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= btn_sync[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    rise = '0;
    for (int i = 0; i < 2; i++) begin
      rise[i] = btn_sync[i] & ~deb[i] & (cnt[i] == CNT_LAST);
    end
  end

`ifdef DIGIT_SEQUENCER_AUTO_RUN_EN
  localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  logic          run_meta;
  logic          run_sync;
  logic [PW-1:0] presc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_meta <= 1'b0;
      run_sync <= 1'b0;
    end else begin
      run_meta <= run;
      run_sync <= run_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (!run_sync || clr) begin
      presc <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign tick = run_sync & (presc == PRESC_LAST);
`else
  assign tick = 1'b0;
`endif

  // Simultaneous up and down cancel each other and also swallow a coincident tick.
  always_comb begin
    code_nxt = code;
    if (clr) begin
      code_nxt = 3'd0;
    end else if (rise[0] && rise[1]) begin
      code_nxt = code;
    end else if (rise[0]) begin
      code_nxt = code + 3'd1;
    end else if (rise[1]) begin
      code_nxt = code - 3'd1;
    end else if (tick) begin
      code_nxt = code + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code <= 3'd0;
      upd  <= 1'b0;
    end else begin
      code <= code_nxt;
      upd  <= (code_nxt != code);
    end
  end

  assign {A, B, C} = code;

endmodule

// File: tb/tb_digit_sequencer.sv
// Directed self-checking bench for digit_sequencer (DEBOUNCE_CYCLES=4, TICK_DIV=8).
// Auto-run checks are compiled only with DIGIT_SEQUENCER_AUTO_RUN_EN.
module tb_digit_sequencer;

  logic clk;
  logic rst_n;
  logic btn_up;
  logic btn_dn;
  logic clr;
  logic run;
  logic A, B, C, upd;
  int   total;
  int   bad;

  digit_sequencer #(.DEBOUNCE_CYCLES(4), .TICK_DIV(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_up (btn_up),
    .btn_dn (btn_dn),
    .clr    (clr),
`ifdef DIGIT_SEQUENCER_AUTO_RUN_EN
    .run    (run),
`endif
    .A      (A),
    .B      (B),
    .C      (C),
    .upd    (upd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_up();
    btn_up = 1'b1;
    step(6);
    btn_up = 1'b0;
    step(6);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    clr    = 1'b0;
    run    = 1'b0;
    #3;
    chk("reset_code", {29'd0, A, B, C}, 32'd0);
    chk("reset_upd", {31'd0, upd}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(3);
    chk("idle_code", {29'd0, A, B, C}, 32'd0);

    // bouncing btn_dn with 3-cycle pulses, then held: single wrap 0 -> 7
    repeat (3) begin
      btn_dn = 1'b1;
      step(3);
      btn_dn = 1'b0;
      step(3);
    end
    chk("bounce_code", {29'd0, A, B, C}, 32'd0);
    chk("bounce_upd", {31'd0, upd}, 32'd0);
    btn_dn = 1'b1;
    step(5);
    chk("dn_before", {29'd0, A, B, C}, 32'd0);
    step(1);
    chk("dn_wrap", {29'd0, A, B, C}, 32'd7);
    chk("dn_upd", {31'd0, upd}, 32'd1);
    step(1);
    chk("dn_upd_off", {31'd0, upd}, 32'd0);
    step(20);
    chk("dn_held", {29'd0, A, B, C}, 32'd7);
    btn_dn = 1'b0;
    step(8);
    chk("dn_release", {29'd0, A, B, C}, 32'd7);

    // btn_up wrap 7 -> 0
    btn_up = 1'b1;
    step(6);
    chk("up_wrap", {29'd0, A, B, C}, 32'd0);
    chk("up_wrap_upd", {31'd0, upd}, 32'd1);
    btn_up = 1'b0;
    step(8);

    // btn_up held: 0 -> 1 exactly once
    btn_up = 1'b1;
    step(5);
    chk("up_before", {29'd0, A, B, C}, 32'd0);
    step(1);
    chk("up_step", {29'd0, A, B, C}, 32'd1);
    chk("up_upd", {31'd0, upd}, 32'd1);
    step(1);
    chk("up_upd_off", {31'd0, upd}, 32'd0);
    step(20);
    chk("up_held", {29'd0, A, B, C}, 32'd1);
    btn_up = 1'b0;
    step(8);

    // both buttons together: no change, no upd
    btn_up = 1'b1;
    btn_dn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("both_code", {29'd0, A, B, C}, 32'd1);
      chk("both_upd", {31'd0, upd}, 32'd0);
    end
    btn_up = 1'b0;
    btn_dn = 1'b0;
    step(8);
    chk("both_release", {29'd0, A, B, C}, 32'd1);

    // climb to 5, then clr coincident with a step_up
    repeat (4) press_up();
    chk("at_five", {29'd0, A, B, C}, 32'd5);
    btn_up = 1'b1;
    step(5);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_wins", {29'd0, A, B, C}, 32'd0);
    chk("clr_upd", {31'd0, upd}, 32'd1);
    btn_up = 1'b0;
    step(8);
    chk("clr_after", {29'd0, A, B, C}, 32'd0);

    // clr at code 0 must not pulse upd
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr0_upd", {31'd0, upd}, 32'd0);

    // reset in the middle of a debounce
    press_up();
    chk("pre_rst", {29'd0, A, B, C}, 32'd1);
    btn_up = 1'b1;
    step(3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_code", {29'd0, A, B, C}, 32'd0);
    chk("async_rst_upd", {31'd0, upd}, 32'd0);
    step(1);
    rst_n = 1'b1;
    step(5);
    chk("post_rst_before", {29'd0, A, B, C}, 32'd0);
    step(1);
    chk("post_rst_step", {29'd0, A, B, C}, 32'd1);
    chk("post_rst_upd", {31'd0, upd}, 32'd1);
    step(10);
    chk("post_rst_held", {29'd0, A, B, C}, 32'd1);
    btn_up = 1'b0;
    step(8);

`ifdef DIGIT_SEQUENCER_AUTO_RUN_EN
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    run = 1'b1;
    step(9);
    chk("run_before", {29'd0, A, B, C}, 32'd0);
    step(1);
    chk("run_first", {29'd0, A, B, C}, 32'd1);
    for (int i = 2; i <= 8; i++) begin
      step(8);
      chk("run_step", {29'd0, A, B, C}, 32'(i % 8));
    end
    step(3);
    run = 1'b0;
    step(20);
    chk("run_hold", {29'd0, A, B, C}, 32'd0);
    // prescaler must restart from 0: first tick again 10 edges after run rises
    run = 1'b1;
    step(9);
    chk("rerun_before", {29'd0, A, B, C}, 32'd0);
    step(1);
    chk("rerun_first", {29'd0, A, B, C}, 32'd1);
    run = 1'b0;
    step(4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
